// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a serial TDM link.
// Hunts for the frame-sync marker, then deserializes NCH slots of W bits,
// MSB first, into per-channel parallel registers with a one-cycle strobe.
// A missing marker at a frame boundary drops lock; a marker anywhere else
// realigns immediately and discards the partial slot.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             fsync,
  output logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  localparam int BW = $clog2(W);
  localparam int SW = $clog2(NCH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
  logic [SW-1:0]     slot_cnt_r, slot_cnt_s;
  // Only W-1 bits need storing: the last bit of a slot arrives on din.
  logic [W-2:0]      shift_r, shift_s;
  logic [W-1:0]      word_s;
  logic [NCH*W-1:0]  ch_data_r, ch_data_s;
  logic [NCH-1:0]    ch_valid_r, ch_valid_s;
  logic              frame_done_r, frame_done_s;
  logic              sync_err_r, sync_err_s;
  logic              locked_r;

  // Next-state, counter, shift and output-pulse logic for one clock.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    slot_cnt_s   = slot_cnt_r;
    shift_s      = shift_r;
    ch_data_s    = ch_data_r;
    ch_valid_s   = '0;
    frame_done_s = 1'b0;
    sync_err_s   = 1'b0;
    word_s       = {shift_r, din};
    if (en) begin
      case (state_r)
        ST_HUNT: begin
          if (fsync) begin
            shift_s    = word_s[W-2:0];
            bit_cnt_s  = BW'(1);
            slot_cnt_s = '0;
            state_s    = ST_LOCKED;
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if ((bit_cnt_r == '0) && (slot_cnt_r == '0)) begin
            // Frame boundary: the marker is mandatory here.
            if (fsync) begin
              shift_s   = word_s[W-2:0];
              bit_cnt_s = BW'(1);
            end else begin
              sync_err_s = 1'b1;
              bit_cnt_s  = '0;
              slot_cnt_s = '0;
              state_s    = ST_HUNT;
            end
          end else if (fsync) begin
            // Marker arrived early: drop the partial slot and realign on it.
            sync_err_s = 1'b1;
            shift_s    = word_s[W-2:0];
            bit_cnt_s  = BW'(1);
            slot_cnt_s = '0;
          end else begin
            shift_s = word_s[W-2:0];
            if (bit_cnt_r == BIT_LAST) begin
              ch_data_s[slot_cnt_r*W +: W] = word_s;
              ch_valid_s[slot_cnt_r]       = 1'b1;
              bit_cnt_s                    = '0;
              if (slot_cnt_r == SLOT_LAST) begin
                frame_done_s = 1'b1;
                slot_cnt_s   = '0;
              end else begin
                slot_cnt_s = slot_cnt_r + SW'(1);
              end
            end else begin
              bit_cnt_s = bit_cnt_r + BW'(1);
            end
          end
        end
        default: begin
          state_s    = ST_HUNT;
          bit_cnt_s  = '0;
          slot_cnt_s = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; reset clears everything back to HUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_HUNT;
      bit_cnt_r    <= '0;
      slot_cnt_r   <= '0;
      shift_r      <= '0;
      ch_data_r    <= '0;
      ch_valid_r   <= '0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      slot_cnt_r   <= slot_cnt_s;
      shift_r      <= shift_s;
      ch_data_r    <= ch_data_s;
      ch_valid_r   <= ch_valid_s;
      frame_done_r <= frame_done_s;
      sync_err_r   <= sync_err_s;
      locked_r     <= (state_s == ST_LOCKED);
    end
  end

  assign ch_data    = ch_data_r;
  assign ch_valid   = ch_valid_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, W=8). Stimulus pushes the expected
// channel update (strobe, full data word, frame_done, cycle) into a queue on
// the edge that carries the last bit of a slot; a negedge monitor pops and
// compares whenever the DUT strobes.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;

  typedef struct {
    logic [NCH-1:0]   v;
    logic [NCH*W-1:0] d;
    logic             fd;
    int               cyc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic             din;
  logic             fsync;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  exp_t             q[$];
  logic [NCH*W-1:0] model;
  int               cyc;
  int               gap;
  int               total;
  int               passed;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .din        (din),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so expected strobe timing can be checked.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ch_valid !== '0 || frame_done !== 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {59'd0, ch_valid, frame_done}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("ch_valid", {60'd0, ch_valid}, {60'd0, e.v});
        chk("ch_data", {32'd0, ch_data}, {32'd0, e.d});
        chk("frame_done", {63'd0, frame_done}, {63'd0, e.fd});
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One qualified edge, followed by gap idle (en=0) cycles.
  task automatic qbit(input logic d, input logic fs);
    en = 1'b1; din = d; fsync = fs;
    @(posedge clk); #1;
    en = 1'b0; din = 1'b0; fsync = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Serial bits of one slot from bit index start; fs0 marks the first one.
  task automatic send_word(input int k, input logic [W-1:0] v, input logic fs0, input int start);
    exp_t e;
    for (int i = start; i < W; i++) begin
      if (i == W - 1) begin
        model[k*W +: W] = v;
        e.v = '0;
        e.v[k] = 1'b1;
        e.d = model;
        e.fd = (k == NCH - 1);
        e.cyc = cyc + 1;
        q.push_back(e);
      end
      qbit(v[W-1-i], fs0 && (i == start));
      if (fs0 && (i == start)) begin
        chk("locked_after_fsync", {63'd0, locked}, 64'd1);
        chk("no_sync_err_on_fsync", {63'd0, sync_err}, 64'd0);
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] v0, input logic [W-1:0] v1,
                            input logic [W-1:0] v2, input logic [W-1:0] v3);
    send_word(0, v0, 1'b1, 0);
    send_word(1, v1, 1'b0, 0);
    send_word(2, v2, 1'b0, 0);
    send_word(3, v3, 1'b0, 0);
  endtask

  task automatic random_bits(input int n);
    for (int i = 0; i < n; i++) qbit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0; cyc = 0; gap = 0; model = '0;
    reset = 1'b1; en = 1'b0; din = 1'b0; fsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ch_data", {32'd0, ch_data}, 64'd0);
    chk("reset_ch_valid", {60'd0, ch_valid}, 64'd0);
    chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
    chk("reset_locked", {63'd0, locked}, 64'd0);
    chk("reset_sync_err", {63'd0, sync_err}, 64'd0);

    // Noise before any marker: nothing decodes.
    random_bits(50);
    chk("hunt_locked", {63'd0, locked}, 64'd0);
    chk("hunt_ch_data", {32'd0, ch_data}, 64'd0);

    // Basic frame, en every cycle.
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("frame1_data", {32'd0, ch_data}, 64'h00FF3CA5);
    chk("frame1_locked", {63'd0, locked}, 64'd1);

    // Same frame, en every third clock.
    gap = 2;
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("slow_frame_data", {32'd0, ch_data}, 64'h00FF3CA5);
    gap = 0;

    // Back-to-back frame, then a missing marker at the next boundary.
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    qbit(1'b1, 1'b0);
    chk("missing_fsync_err", {63'd0, sync_err}, 64'd1);
    chk("missing_fsync_unlock", {63'd0, locked}, 64'd0);
    qbit(1'b0, 1'b0);
    chk("sync_err_one_cycle", {63'd0, sync_err}, 64'd0);
    random_bits(20);
    chk("unlocked_stays", {63'd0, locked}, 64'd0);
    chk("retained_data", {32'd0, ch_data}, 64'h44332211);

    // Early marker at slot 1 bit 3 realigns without dropping lock.
    send_word(0, 8'h5A, 1'b1, 0);
    qbit(1'b1, 1'b0); qbit(1'b0, 1'b0); qbit(1'b1, 1'b0);
    qbit(1'b1, 1'b1);
    chk("early_fsync_err", {63'd0, sync_err}, 64'd1);
    chk("early_fsync_locked", {63'd0, locked}, 64'd1);
    chk("early_slot1_kept", {56'd0, ch_data[15:8]}, 64'h22);
    send_word(0, 8'hC3, 1'b0, 1);
    chk("early_err_cleared", {63'd0, sync_err}, 64'd0);
    send_word(1, 8'h96, 1'b0, 0);
    send_word(2, 8'h0F, 1'b0, 0);
    send_word(3, 8'hE1, 1'b0, 0);
    chk("realigned_data", {32'd0, ch_data}, 64'hE10F96C3);
    chk("realigned_locked", {63'd0, locked}, 64'd1);

    // Reset at slot 2 bit 5 after slots 0 and 1 updated.
    send_word(0, 8'h77, 1'b1, 0);
    send_word(1, 8'h88, 1'b0, 0);
    for (int i = 0; i < 5; i++) qbit(1'b1, 1'b0);
    reset = 1'b1; en = 1'b1; din = 1'b1; fsync = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b0; din = 1'b0;
    model = '0;
    chk("midreset_ch_data", {32'd0, ch_data}, 64'd0);
    chk("midreset_ch_valid", {60'd0, ch_valid}, 64'd0);
    chk("midreset_locked", {63'd0, locked}, 64'd0);
    chk("midreset_sync_err", {63'd0, sync_err}, 64'd0);
    chk("midreset_frame_done", {63'd0, frame_done}, 64'd0);
    random_bits(40);
    chk("post_reset_locked", {63'd0, locked}, 64'd0);
    chk("post_reset_data", {32'd0, ch_data}, 64'd0);

    // Recovery after reset.
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    chk("recovered_data", {32'd0, ch_data}, 64'hEFBEADDE);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
